seq_mult8_controller: RTL and testbench



---
 rtl/seq_mult8_controller_pkg.sv | 14 +
 rtl/eight_bit_full_adder_module.sv | 15 +
 rtl/seq_mult8_controller.sv | 132 +++++++++++++
 tb/tb_seq_mult8_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult8_controller_pkg.sv
// Shared constants and state encoding for the sequential 8x8 multiplier.
package seq_mult8_controller_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned PROD_W     = 2 * DATA_W;
   localparam int unsigned MULT_STEPS = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/eight_bit_full_adder_module.sv
// 8-bit ripple adder with carry in/out; the one adder time-shared by the multiplier.
module eight_bit_full_adder_module
   import seq_mult8_controller_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   // 9-bit sum so the carry out is never lost
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};

endmodule

// File: rtl/seq_mult8_controller.sv
// Sequential 8x8 unsigned shift-add multiplier with valid/ready on both sides.
// Operands are accepted in IDLE only; CALC runs 8 add/shift steps; DONE holds the
// product until the consumer takes it.
module seq_mult8_controller
   import seq_mult8_controller_pkg::*;
#(
   parameter bit ZERO_SKIP = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic [DATA_W-1:0] product_lo,
   output logic              overflow,
   output logic              busy
);

   localparam int unsigned      CNT_W     = 3;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULT_STEPS - 1);

   state_t              r_state;
   logic [PROD_W-1:0]   r_p;
   logic [DATA_W-1:0]   r_a;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_busy;
   logic [PROD_W-1:0]   r_product;
   logic                r_overflow;

   logic [DATA_W-1:0]   w_addend;
   logic [DATA_W-1:0]   w_sum;
   logic                w_cout;
   logic [PROD_W-1:0]   w_p_step;
   logic                w_zero_op;

   // Multiplicand is only added when the current multiplier LSB is set
   assign w_addend = r_p[0] ? r_a : '0;

   eight_bit_full_adder_module u_adder (
      .a    (r_p[PROD_W-1:DATA_W]),
      .b    (w_addend),
      .cin  (1'b0),
      .sum  (w_sum),
      .cout (w_cout)
   );

   // With LSB clear the adder passes P[15:8] through, so one form covers both step kinds
   assign w_p_step  = {w_cout, w_sum, r_p[DATA_W-1:1]};
   assign w_zero_op = ZERO_SKIP && ((a == '0) || (b == '0));

   // Control FSM, step counter, shift register and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_p         <= '0;
         r_a         <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_product   <= '0;
         r_overflow  <= 1'b0;
      end else if (clear) begin
         // Abort: any in-flight or pending result is dropped, in_valid is ignored
         r_state     <= ST_IDLE;
         r_p         <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  if (w_zero_op) begin
                     r_p         <= '0;
                     r_product   <= '0;
                     r_overflow  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_p     <= {{DATA_W{1'b0}}, b};
                     r_state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_p   <= w_p_step;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_STEP) begin
                  r_product   <= w_p_step;
                  r_overflow  <= |w_p_step[PROD_W-1:DATA_W];
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b1;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign busy       = r_busy;
   assign product    = r_product;
   assign product_lo = r_product[DATA_W-1:0];
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_seq_mult8_controller.sv
// Self-checking bench for seq_mult8_controller: directed corner cases plus
// randomized operands against a plain a*b reference model.
module tb_seq_mult8_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, clear, out_valid, out_ready, overflow, busy;
   logic [7:0]  a, b, product_lo;
   logic [15:0] product;

   logic        zs_in_valid, zs_in_ready, zs_clear, zs_out_valid, zs_out_ready;
   logic        zs_overflow, zs_busy;
   logic [7:0]  zs_a, zs_b, zs_product_lo;
   logic [15:0] zs_product;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mult8_controller #(.ZERO_SKIP(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .product    (product),
      .product_lo (product_lo),
      .overflow   (overflow),
      .busy       (busy)
   );

   seq_mult8_controller #(.ZERO_SKIP(1'b1)) dut_zs (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (zs_in_valid),
      .in_ready   (zs_in_ready),
      .a          (zs_a),
      .b          (zs_b),
      .clear      (zs_clear),
      .out_valid  (zs_out_valid),
      .out_ready  (zs_out_ready),
      .product    (zs_product),
      .product_lo (zs_product_lo),
      .overflow   (zs_overflow),
      .busy       (zs_busy)
   );

   // Transaction driver: returns observations only, callers do the comparing.
   // Entered and left at 1 time unit after a rising edge.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat,
                        output logic [15:0] p, output logic [7:0] lo, output logic ov,
                        output logic rdy_after);
      a = av; b = bv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      p = product; lo = product_lo; ov = overflow;
      rdy_after = 1'b0;
      if (lat != 99) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         rdy_after = in_ready;
      end
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
      checks++; if (product_lo !== 8'h00) begin errors++; $display("FAIL reset_product_lo got %h want 00", product_lo); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
   endtask

   task automatic test_basic();
      int lat; logic [15:0] p; logic [7:0] lo; logic ov, rdy;
      do_op(8'd3, 8'd5, lat, p, lo, ov, rdy);
      checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
      checks++; if (p !== 16'h000F) begin errors++; $display("FAIL basic_product got %h want 000f", p); end
      checks++; if (lo !== 8'h0F) begin errors++; $display("FAIL basic_product_lo got %h want 0f", lo); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b want 0", ov); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after got %b want 1", rdy); end
   endtask

   task automatic test_boundary();
      int lat; logic [15:0] p; logic [7:0] lo; logic ov, rdy;
      do_op(8'd255, 8'd255, lat, p, lo, ov, rdy);
      checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL max_product got %h want fe01", p); end
      checks++; if (lo !== 8'h01) begin errors++; $display("FAIL max_product_lo got %h want 01", lo); end
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL max_overflow got %b want 1", ov); end
      do_op(8'd16, 8'd16, lat, p, lo, ov, rdy);
      checks++; if (p !== 16'h0100) begin errors++; $display("FAIL p256_product got %h want 0100", p); end
      checks++; if (lo !== 8'h00) begin errors++; $display("FAIL p256_product_lo got %h want 00", lo); end
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL p256_overflow got %b want 1", ov); end
   endtask

   task automatic test_random();
      int lat; logic [15:0] p, exp_p; logic [7:0] lo, av, bv; logic ov, rdy;
      for (int n = 0; n < 24; n++) begin
         av = 8'($urandom_range(0, 255));
         bv = 8'($urandom_range(0, 255));
         exp_p = 16'(av) * 16'(bv);
         do_op(av, bv, lat, p, lo, ov, rdy);
         checks++; if (lat !== 8) begin errors++; $display("FAIL rand_latency %0d*%0d got %0d want 8", av, bv, lat); end
         checks++; if (p !== exp_p) begin errors++; $display("FAIL rand_product %0d*%0d got %h want %h", av, bv, p, exp_p); end
         checks++; if (lo !== exp_p[7:0]) begin errors++; $display("FAIL rand_product_lo %0d*%0d got %h want %h", av, bv, lo, exp_p[7:0]); end
         checks++; if (ov !== (exp_p > 16'd255)) begin errors++; $display("FAIL rand_overflow %0d*%0d got %b want %b", av, bv, ov, exp_p > 16'd255); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      a = 8'd12; b = 8'd10; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      // second operand presented immediately and held
      a = 8'd33; b = 8'd7;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_calc got %b want 0", in_ready); end
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency got %0d want 8", lat); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", i, out_valid); end
         checks++; if (product !== 16'h0078) begin errors++; $display("FAIL bp_hold_product cycle %0d got %h want 0078", i, product); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cycle %0d got %b want 0", i, in_ready); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got %b want 0", in_ready); end
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL bp_second_latency got %0d want 8", lat); end
      checks++; if (product !== 16'd231) begin errors++; $display("FAIL bp_second_product got %h want 00e7", product); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_zero_skip();
      int lat; logic [15:0] p; logic [7:0] lo, av; logic ov, rdy;
      for (int n = 0; n < 3; n++) begin
         av = 8'($urandom_range(1, 255));
         zs_a = (n == 0) ? 8'd0 : av;
         zs_b = (n == 0) ? 8'd77 : 8'd0;
         zs_in_valid = 1'b1;
         @(posedge clk); #1;
         zs_in_valid = 1'b0;
         checks++; if (zs_out_valid !== 1'b1) begin errors++; $display("FAIL zs_fast_valid case %0d got %b want 1", n, zs_out_valid); end
         checks++; if (zs_product !== 16'h0000) begin errors++; $display("FAIL zs_fast_product case %0d got %h want 0000", n, zs_product); end
         checks++; if (zs_overflow !== 1'b0) begin errors++; $display("FAIL zs_fast_overflow case %0d got %b want 0", n, zs_overflow); end
         zs_out_ready = 1'b1;
         @(posedge clk); #1;
         zs_out_ready = 1'b0;
         checks++; if (zs_in_ready !== 1'b1) begin errors++; $display("FAIL zs_in_ready_after case %0d got %b want 1", n, zs_in_ready); end
      end
      // nonzero operands still take the full path on the skipping instance
      zs_a = 8'd13; zs_b = 8'd21; zs_in_valid = 1'b1;
      @(posedge clk); #1;
      zs_in_valid = 1'b0;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (zs_out_valid) begin lat = i; break; end
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL zs_full_latency got %0d want 8", lat); end
      checks++; if (zs_product !== 16'd273) begin errors++; $display("FAIL zs_full_product got %h want 0111", zs_product); end
      checks++; if (zs_product_lo !== 8'h11 || zs_busy !== 1'b1) begin errors++; $display("FAIL zs_full_lo_busy got %h/%b want 11/1", zs_product_lo, zs_busy); end
      zs_out_ready = 1'b1;
      @(posedge clk); #1;
      zs_out_ready = 1'b0;
      // same zero operand without skipping: full latency
      do_op(8'd0, 8'd77, lat, p, lo, ov, rdy);
      checks++; if (lat !== 8) begin errors++; $display("FAIL noskip_latency got %0d want 8", lat); end
      checks++; if (p !== 16'h0000) begin errors++; $display("FAIL noskip_product got %h want 0000", p); end
   endtask

   task automatic test_clear();
      int lat; logic [15:0] p; logic [7:0] lo; logic ov, rdy, seen;
      a = 8'd9; b = 8'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_before got %b want 1", busy); end
      clear = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clear_idle got ready %b busy %b want 1/0", in_ready, busy); end
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clear_no_result got %b want 0", seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_not_accepted got busy %b want 0", busy); end
      do_op(8'd2, 8'd7, lat, p, lo, ov, rdy);
      checks++; if (p !== 16'h000E || lat !== 8) begin errors++; $display("FAIL clear_next_op got %h lat %0d want 000e lat 8", p, lat); end
   endtask

   task automatic test_async_reset();
      int lat; logic [15:0] p; logic [7:0] lo; logic ov, rdy, seen;
      a = 8'd200; b = 8'd200; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b want 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
      checks++; if (product !== 16'h0000 || product_lo !== 8'h00) begin errors++; $display("FAIL areset_product got %h/%h want 0000/00", product, product_lo); end
      checks++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL areset_flags got %b/%b want 0/0", out_valid, overflow); end
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL areset_no_result got %b want 0", seen); end
      do_op(8'd100, 8'd3, lat, p, lo, ov, rdy);
      checks++; if (p !== 16'h012C) begin errors++; $display("FAIL areset_next_product got %h want 012c", p); end
      checks++; if (ov !== 1'b1 || lo !== 8'h2C) begin errors++; $display("FAIL areset_next_ov_lo got %b/%h want 1/2c", ov, lo); end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; clear = 1'b0; out_ready = 1'b0;
      zs_in_valid = 1'b0; zs_a = '0; zs_b = '0; zs_clear = 1'b0; zs_out_ready = 1'b0;
      #12;
      test_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      test_basic();
      test_boundary();
      test_random();
      test_backpressure();
      test_zero_skip();
      test_clear();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
